// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - ID-stage beq/bne resolver with mispredict flush/redirect and saturating stats
module branch_resolver #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              if_valid,
  input  logic              if_B,
  input  logic              if_bne,
  input  logic              if_BrPre,
  input  logic [ADDR_W-1:0] if_pc_plus4,
  input  logic [ADDR_W-1:0] if_target,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  output logic              B,
  output logic              PreWrong,
  output logic              flush,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [CNT_W-1:0]  br_count,
  output logic [CNT_W-1:0]  miss_count
);

  // IF/ID register fields for the instruction currently in ID
  logic              r_valid;
  logic              r_b;
  logic              r_bne;
  logic              r_pred;
  logic [ADDR_W-1:0] r_pc_plus4;
  logic [ADDR_W-1:0] r_target;

  logic [CNT_W-1:0]  r_br_count;
  logic [CNT_W-1:0]  r_miss_count;

  logic              w_eq;
  logic              w_taken;
  logic              w_b;
  logic              w_prewrong;
  logic              w_flush;
  logic              w_count_en;
  logic              w_br_sat;
  logic              w_miss_sat;

  // Resolve the ID branch from the forwarded operands and its recorded prediction
  always_comb begin
    w_eq       = (id_rs_data == id_rt_data);
    w_taken    = r_bne ? ~w_eq : w_eq;
    w_b        = r_valid & r_b;
    w_prewrong = w_b & (w_taken != r_pred);
    // Under stall the PC unit does not load, so the wrong-path kill must wait too
    w_flush    = w_prewrong & ~stall;
    w_count_en = w_b & ~stall;
    w_br_sat   = (r_br_count == {CNT_W{1'b1}});
    w_miss_sat = (r_miss_count == {CNT_W{1'b1}});
  end

  // IF/ID register: hold on stall, bubble on flush, otherwise capture the fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_b        <= 1'b0;
      r_bne      <= 1'b0;
      r_pred     <= 1'b0;
      r_pc_plus4 <= '0;
      r_target   <= '0;
    end else if (!stall) begin
      if (w_flush) begin
        r_valid <= 1'b0;
        r_b     <= 1'b0;
      end else begin
        r_valid    <= if_valid;
        r_b        <= if_B;
        r_bne      <= if_bne;
        r_pred     <= if_BrPre;
        r_pc_plus4 <= if_pc_plus4;
        r_target   <= if_target;
      end
    end
  end

  // Saturating statistics; each ID occupant sees one unstalled edge so it counts once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else if (w_count_en) begin
      if (!w_br_sat) begin
        r_br_count <= r_br_count + 1'b1;
      end
      if (w_prewrong && !w_miss_sat) begin
        r_miss_count <= r_miss_count + 1'b1;
      end
    end
  end

  // Drive outputs; redirect_pc is only meaningful while flush is high
  always_comb begin
    B           = w_b;
    PreWrong    = w_prewrong;
    flush       = w_flush;
    redirect_pc = w_taken ? r_target : r_pc_plus4;
    br_count    = r_br_count;
    miss_count  = r_miss_count;
  end

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver
module tb_branch_resolver;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        if_valid;
  logic        if_B;
  logic        if_bne;
  logic        if_BrPre;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_target;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        B;
  logic        PreWrong;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [15:0] br_count;
  logic [15:0] miss_count;

  logic        s_B;
  logic        s_PreWrong;
  logic        s_flush;
  logic [31:0] s_redirect_pc;
  logic [3:0]  s_br_count;
  logic [3:0]  s_miss_count;

  int checks;
  int failures;

  branch_resolver dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_B        (if_B),
    .if_bne      (if_bne),
    .if_BrPre    (if_BrPre),
    .if_pc_plus4 (if_pc_plus4),
    .if_target   (if_target),
    .id_rs_data  (id_rs_data),
    .id_rt_data  (id_rt_data),
    .B           (B),
    .PreWrong    (PreWrong),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .br_count    (br_count),
    .miss_count  (miss_count)
  );

  // Narrow-counter instance so saturation is reachable in a short run
  branch_resolver #(.CNT_W(4)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .if_valid    (if_valid),
    .if_B        (if_B),
    .if_bne      (if_bne),
    .if_BrPre    (if_BrPre),
    .if_pc_plus4 (if_pc_plus4),
    .if_target   (if_target),
    .id_rs_data  (id_rs_data),
    .id_rt_data  (id_rt_data),
    .B           (s_B),
    .PreWrong    (s_PreWrong),
    .flush       (s_flush),
    .redirect_pc (s_redirect_pc),
    .br_count    (s_br_count),
    .miss_count  (s_miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_nop();
    if_valid    = 1'b1;
    if_B        = 1'b0;
    if_bne      = 1'b0;
    if_BrPre    = 1'b0;
    if_pc_plus4 = 32'h0;
    if_target   = 32'h0;
  endtask

  task automatic fetch_br(input logic bne, input logic pred, input logic [31:0] pc4, input logic [31:0] tgt);
    if_valid    = 1'b1;
    if_B        = 1'b1;
    if_bne      = bne;
    if_BrPre    = pred;
    if_pc_plus4 = pc4;
    if_target   = tgt;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    stall    = 1'b0;
    id_rs_data = 32'h0;
    id_rt_data = 32'h0;
    fetch_nop();
    tick();
    tick();
    chk("rst_B", {31'b0, B}, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    rst = 1'b0;

    // Mispredicted branch into ID, then async reset mid-cycle
    fetch_br(1'b0, 1'b0, 32'h100, 32'h180);
    id_rs_data = 32'h7;
    id_rt_data = 32'h7;
    tick();
    chk("pre_rst_prewrong", {31'b0, PreWrong}, 32'h1);
    chk("pre_rst_flush", {31'b0, flush}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_B", {31'b0, B}, 32'h0);
    chk("async_rst_prewrong", {31'b0, PreWrong}, 32'h0);
    chk("async_rst_flush", {31'b0, flush}, 32'h0);
    chk("async_rst_br", {16'b0, br_count}, 32'h0);
    chk("async_rst_miss", {16'b0, miss_count}, 32'h0);
    #1 rst = 1'b0;
    fetch_nop();
    tick();
    chk("nop_B", {31'b0, B}, 32'h0);
    chk("nop_flush", {31'b0, flush}, 32'h0);
    tick();
    chk("nop_br", {16'b0, br_count}, 32'h0);
    chk("nop_miss", {16'b0, miss_count}, 32'h0);

    // Correct not-taken beq
    fetch_br(1'b0, 1'b0, 32'h104, 32'h300);
    id_rs_data = 32'h5;
    id_rt_data = 32'h6;
    tick();
    fetch_nop();
    chk("cnt_B", {31'b0, B}, 32'h1);
    chk("cnt_prewrong", {31'b0, PreWrong}, 32'h0);
    chk("cnt_flush", {31'b0, flush}, 32'h0);
    tick();
    chk("cnt_br", {16'b0, br_count}, 32'h1);
    chk("cnt_miss", {16'b0, miss_count}, 32'h0);

    // Mispredicted taken bne
    fetch_br(1'b1, 1'b0, 32'h110, 32'h200);
    id_rs_data = 32'h1;
    id_rt_data = 32'h2;
    tick();
    fetch_nop();
    chk("mt_prewrong", {31'b0, PreWrong}, 32'h1);
    chk("mt_flush", {31'b0, flush}, 32'h1);
    chk("mt_redirect", redirect_pc, 32'h200);
    tick();
    chk("mt_bubble_B", {31'b0, B}, 32'h0);
    chk("mt_br", {16'b0, br_count}, 32'h2);
    chk("mt_miss", {16'b0, miss_count}, 32'h1);

    // Mispredicted not-taken beq; the wrong-path branch behind it must vanish
    fetch_br(1'b0, 1'b1, 32'h108, 32'h400);
    id_rs_data = 32'h3;
    id_rt_data = 32'h4;
    tick();
    chk("mn_flush", {31'b0, flush}, 32'h1);
    chk("mn_redirect", redirect_pc, 32'h108);
    fetch_br(1'b1, 1'b0, 32'h10c, 32'h700);
    tick();
    fetch_nop();
    chk("wp_B", {31'b0, B}, 32'h0);
    chk("wp_prewrong", {31'b0, PreWrong}, 32'h0);
    chk("wp_flush", {31'b0, flush}, 32'h0);
    tick();
    chk("wp_br", {16'b0, br_count}, 32'h3);
    chk("wp_miss", {16'b0, miss_count}, 32'h2);

    // Correct taken beq followed directly by a mispredicted bne
    fetch_br(1'b0, 1'b1, 32'h11c, 32'h500);
    id_rs_data = 32'h9;
    id_rt_data = 32'h9;
    tick();
    chk("b2b_first_B", {31'b0, B}, 32'h1);
    chk("b2b_first_prewrong", {31'b0, PreWrong}, 32'h0);
    fetch_br(1'b1, 1'b1, 32'h124, 32'h520);
    tick();
    fetch_nop();
    chk("b2b_second_B", {31'b0, B}, 32'h1);
    chk("b2b_second_prewrong", {31'b0, PreWrong}, 32'h1);
    chk("b2b_second_redirect", redirect_pc, 32'h124);
    chk("b2b_br_mid", {16'b0, br_count}, 32'h4);
    tick();
    chk("b2b_br", {16'b0, br_count}, 32'h5);
    chk("b2b_miss", {16'b0, miss_count}, 32'h3);

    // Mispredict held under a 3-cycle stall
    fetch_br(1'b1, 1'b1, 32'h130, 32'h540);
    id_rs_data = 32'h8;
    id_rt_data = 32'h8;
    tick();
    fetch_nop();
    stall = 1'b1;
    #1;
    chk("st_prewrong", {31'b0, PreWrong}, 32'h1);
    chk("st_flush0", {31'b0, flush}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("st_flush_hold", {31'b0, flush}, 32'h0);
      chk("st_br_hold", {16'b0, br_count}, 32'h5);
      chk("st_miss_hold", {16'b0, miss_count}, 32'h3);
    end
    stall = 1'b0;
    #1;
    chk("st_release_flush", {31'b0, flush}, 32'h1);
    chk("st_release_redirect", redirect_pc, 32'h130);
    tick();
    chk("st_after_flush", {31'b0, flush}, 32'h0);
    chk("st_br", {16'b0, br_count}, 32'h6);
    chk("st_miss", {16'b0, miss_count}, 32'h4);

    // Late forwarding: operands change during stall and flip the outcome
    fetch_br(1'b0, 1'b0, 32'h140, 32'h600);
    id_rs_data = 32'h1;
    id_rt_data = 32'h2;
    tick();
    fetch_nop();
    stall = 1'b1;
    #1;
    chk("lf_prewrong_early", {31'b0, PreWrong}, 32'h0);
    id_rs_data = 32'h2;
    #1;
    chk("lf_prewrong_late", {31'b0, PreWrong}, 32'h1);
    chk("lf_flush_stalled", {31'b0, flush}, 32'h0);
    tick();
    chk("lf_br_hold", {16'b0, br_count}, 32'h6);
    stall = 1'b0;
    #1;
    chk("lf_flush", {31'b0, flush}, 32'h1);
    chk("lf_redirect", redirect_pc, 32'h600);
    tick();
    chk("lf_br", {16'b0, br_count}, 32'h7);
    chk("lf_miss", {16'b0, miss_count}, 32'h5);

    // Saturation: 15 mispredicts fill the 4-bit counters, one more must not wrap
    rst = 1'b1;
    #2 rst = 1'b0;
    id_rs_data = 32'h0;
    id_rt_data = 32'h0;
    for (int i = 0; i < 15; i++) begin
      fetch_br(1'b0, 1'b0, 32'h800, 32'h900);
      tick();
      fetch_nop();
      tick();
    end
    chk("sat_fill_br", {28'b0, s_br_count}, 32'hF);
    chk("sat_fill_miss", {28'b0, s_miss_count}, 32'hF);
    fetch_br(1'b0, 1'b0, 32'h800, 32'h900);
    tick();
    fetch_nop();
    chk("sat_last_prewrong", {31'b0, s_PreWrong}, 32'h1);
    tick();
    chk("sat_br", {28'b0, s_br_count}, 32'hF);
    chk("sat_miss", {28'b0, s_miss_count}, 32'hF);
    chk("wide_br", {16'b0, br_count}, 32'h10);
    chk("wide_miss", {16'b0, miss_count}, 32'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolves conditional branches (beq/bne) in the ID stage and closes the loop with the 2-bit branch prediction unit. Carries each fetched branch's prediction and candidate PCs from IF into an internal IF/ID register, compares the register operands, and detects mispredictions. On a misprediction it drives PreWrong and B back to the predictor, flushes the wrong-path IF instruction and redirects the PC. Saturating branch and mispredict counters support performance analysis.

## Interface
- ADDR_W, 32, PC width
- DATA_W, 32, register operand width
- CNT_W, 16, statistics counter width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- stall  in  1  stall from cache or hazard unit; freezes all state
- if_valid  in  1  IF instruction valid
- if_B  in  1  IF instruction is beq/bne (predecode)
- if_bne  in  1  1 = bne, 0 = beq
- if_BrPre  in  1  predictor output for this fetch; 1 = taken
- if_pc_plus4  in  ADDR_W  fall-through PC
- if_target  in  ADDR_W  taken target PC
- id_rs_data  in  DATA_W  forwarded rs value for the ID instruction
- id_rt_data  in  DATA_W  forwarded rt value for the ID instruction
- B  out  1  ID instruction is a valid branch; to predictor
- PreWrong  out  1  misprediction; to predictor
- flush  out  1  kill the instruction currently in IF
- redirect_pc  out  ADDR_W  corrected fetch PC, meaningful when flush = 1
- br_count  out  CNT_W  resolved branches, saturating
- miss_count  out  CNT_W  mispredictions, saturating

## Operation
- IF/ID register fields: valid, B, bne, pred, pc_plus4, target.
- Register update on a clock edge:
  - stall = 1: hold.
  - stall = 0 and flush = 1: load a bubble (valid = 0, B = 0; other fields don't-care).
  - Otherwise: load the if_* inputs.
- Combinational resolve from the register:
  - eq = (id_rs_data == id_rt_data), full DATA_W compare.
  - taken = bne ? ~eq : eq.
  - B = valid & B_reg.
  - PreWrong = B & (taken != pred).
  - flush = PreWrong & ~stall.
  - redirect_pc = taken ? target : pc_plus4.
- A non-branch or invalid instruction in ID drives B = 0, PreWrong = 0, flush = 0. redirect_pc is don't-care in that case.
- Counters update only on an edge where stall = 0 and B = 1:
  - br_count += 1.
  - miss_count += 1 if PreWrong.
  - Both saturate at 2^CNT_W − 1 and never wrap.
- Each ID occupant sees exactly one non-stalled edge, so each branch is counted once.

## Timing
- Reset (async, immediate): register valid = 0, B = 0; br_count = 0, miss_count = 0. Therefore B, PreWrong and flush are 0 during and after reset, and redirect_pc is don't-care.
- Latency: a branch fetched in cycle n resolves combinationally in cycle n+1, provided the cycle-n edge is not stalled.
  - The predictor samples PreWrong/B at the end of cycle n+1.
  - The PC unit loads redirect_pc at the same edge.
  - The IF instruction of cycle n+1 is replaced by a bubble.
- Stall during resolve:
  - B and PreWrong stay asserted, but the predictor ignores them under stall.
  - flush is 0; no counting.
  - Resolution repeats with current operands on the first unstalled cycle.
- Back-to-back branches: the branch fetched in the flush cycle is discarded, so no second PreWrong arises from the wrong path. A correctly predicted branch followed by a branch resolves both in consecutive cycles.
- Operand change while stalled (late forwarding): the final decision uses the values present on the unstalled cycle.
- rst asserted mid-operation: everything clears immediately, including a pending flush. First fetch after release resolves normally.

## Test plan
- Reset: assert rst with a branch in ID -> B = 0, PreWrong = 0, flush = 0, br_count = 0, miss_count = 0 immediately; release, fetch a non-branch -> all stay 0.
- Correct not-taken: beq, if_BrPre = 0, rs = 5, rt = 6, pc_plus4 = 0x104 -> next cycle B = 1, PreWrong = 0, flush = 0; after the edge br_count = 1, miss_count = 0.
- Mispredict taken: bne, if_BrPre = 0, rs = 1, rt = 2, target = 0x200 -> PreWrong = 1, flush = 1, redirect_pc = 0x200; next cycle B = 0 (bubble), miss_count = 1.
- Mispredict not-taken: beq, if_BrPre = 1, rs = 3, rt = 4, pc_plus4 = 0x108 -> flush = 1, redirect_pc = 0x108; the wrong-path branch fetched that cycle is never resolved.
- Stall: mispredicted branch in ID with stall = 1 for 3 cycles -> flush = 0 and counters unchanged throughout; stall drops -> flush = 1 for exactly one cycle and miss_count increments by exactly 1.
- Saturation: preload via 65535 mispredicted branches, then one more -> br_count = miss_count = 0xFFFF, unchanged.
